decade_counter_ctrl: RTL and testbench
======================================

DECADE_COUNTER_CTRL -- requirements
Module: decade_counter_ctrl

Interface
REQ-001 Parameter PULSE_W, default 1, meaning the width in CP cycles of every CPu, CPd or PL_n low pulse, every MR high pulse, and every recovery phase (legal range 1-15).
REQ-002 CP  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 MR_n  input  1  asynchronous, active-low reset.
REQ-004 up_req  input  1  count-up request; level, held until ack.
REQ-005 dn_req  input  1  count-down request; level, held until ack.
REQ-006 ld_req  input  1  parallel-load request; level, held until ack.
REQ-007 ld_val  input  4  value to load, sampled when ld_req is accepted.
REQ-008 clr_req  input  1  clear request; level, held until ack.
REQ-009 ack  output  1  one-cycle pulse when the accepted operation completes.
REQ-010 err  output  1  one-cycle pulse coincident with ack for a rejected load.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 CPu, CPd  output  1 each  count clocks to the counter; idle high.
REQ-013 PL_n  output  1  active-low parallel load to the counter.
REQ-014 MR  output  1  active-high master reset to the counter.
REQ-015 P3, P2, P1, P0  output  1 each  parallel data to the counter.
REQ-016 cnt  output  4  shadow of the counter value, BCD 0-9.
REQ-017 tc_up, tc_dn  output  1 each  terminal-count flags: cnt==9 and cnt==0 respectively.

Function
REQ-018 All control outputs shall be registered, with no combinational path from any request input to CPu, CPd, PL_n, MR or P3-P0.
REQ-019 The FSM states shall be IDLE, CLR, LOAD, UP_LO, DN_LO, REC.
REQ-020 Requests shall be accepted only in IDLE, with priority clr_req > ld_req > (up_req/dn_req).
REQ-021 If up_req and dn_req are both high with no higher-priority request, both shall be acknowledged together: ack pulses the next cycle, no CPu/CPd pulse is issued, and cnt is unchanged.
REQ-022 Up operation: CPu low for PULSE_W cycles (UP_LO), then CPu high for PULSE_W cycles (REC); CPd shall stay high throughout.
REQ-023 Down operation: identical to the up operation with CPd pulsed; CPu shall stay high throughout.
REQ-024 cnt shall update on the edge where CPu or CPd returns high: up wraps 9->0, down wraps 0->9.
REQ-025 Load operation: P3-P0 are driven with the captured ld_val, PL_n is low for PULSE_W cycles, then REC with P3-P0 held; cnt takes ld_val when PL_n rises.
REQ-026 A load with ld_val > 9 shall be rejected: no PL_n pulse, ack and err pulse together the next cycle, and cnt is unchanged.
REQ-027 Clear operation: MR high for PULSE_W cycles, then REC with MR low; cnt becomes 0 when MR falls.
REQ-028 ack shall pulse for one cycle on the last REC cycle, and the FSM returns to IDLE on the following edge.
REQ-029 With PULSE_W=1, an accepted operation shall have ack high in the second cycle after acceptance and busy high for two cycles.
REQ-030 Requesters shall drop their request in the cycle ack is high; a request still high in IDLE after that is treated as a new request.
REQ-031 Requests arriving while busy shall be ignored until IDLE.
REQ-032 At most one of CPu low, CPd low, PL_n low or MR high shall ever be active.
REQ-033 P3-P0 shall hold their last driven value outside load operations.

Reset
REQ-034 While MR_n is low: state=IDLE, CPu=1, CPd=1, PL_n=1, MR=1, P3-P0=0, cnt=0, ack=0, err=0, busy=0.
REQ-035 On the first CP edge after MR_n rises, MR shall go to 0.
REQ-036 MR_n asserted mid-operation shall abort that operation immediately with no ack, and all outputs take their reset values.

Verification
REQ-037 Reset release, then load ld_val=5 -> PL_n low 1 cycle with P3..P0=0101, ack two cycles after acceptance, cnt=5.
REQ-038 From cnt=5, two up requests then two down requests -> two CPu pulses (cnt=7), then two CPd pulses (cnt=5), with the other count clock high throughout.
REQ-039 Load 9, then up -> cnt=0 and tc_up goes 1->0; down from 0 -> cnt=9.
REQ-040 up_req and dn_req raised together -> ack next cycle, no clock pulse, cnt unchanged; clr_req with ld_req -> clear wins, cnt=0, and load is served after.
REQ-041 Load ld_val=12 -> ack and err pulse together, PL_n stays 1, cnt unchanged.
REQ-042 With PULSE_W=3, MR_n pulsed low during UP_LO -> CPu=1 and MR=1 immediately, cnt=0, no ack.

Source files
------------

// File: rtl/decade_counter_ctrl.sv
// Handshake controller for a 74x192-style BCD up/down counter: turns level requests
// into registered CPu/CPd/PL_n/MR pulses of PULSE_W cycles and keeps a shadow count.
module decade_counter_ctrl #(
    parameter int unsigned PULSE_W = 1
) (
    input  logic       CP,
    input  logic       MR_n,
    input  logic       up_req,
    input  logic       dn_req,
    input  logic       ld_req,
    input  logic [3:0] ld_val,
    input  logic       clr_req,
    output logic       ack,
    output logic       err,
    output logic       busy,
    output logic       CPu,
    output logic       CPd,
    output logic       PL_n,
    output logic       MR,
    output logic       P3,
    output logic       P2,
    output logic       P1,
    output logic       P0,
    output logic [3:0] cnt,
    output logic       tc_up,
    output logic       tc_dn
);

    localparam logic [3:0] W_LAST = 4'(PULSE_W - 1);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, UP_LO, DN_LO, REC} state_t;

    state_t     r_state;
    logic [3:0] r_tmr;
    logic [3:0] r_cnt;
    logic [3:0] r_p;
    logic       r_ack;
    logic       r_err;
    logic       r_cpu;
    logic       r_cpd;
    logic       r_pl_n;
    logic       r_mr;

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            r_state <= IDLE;
            r_tmr   <= 4'd0;
            r_cnt   <= 4'd0;
            r_p     <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_cpu   <= 1'b1;
            r_cpd   <= 1'b1;
            r_pl_n  <= 1'b1;
            r_mr    <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_mr <= 1'b0;
                    // A request that completed within IDLE is still high during its ack cycle.
                    if (!r_ack) begin
                        if (clr_req) begin
                            r_state <= CLR;
                            r_mr    <= 1'b1;
                            r_tmr   <= W_LAST;
                        end else if (ld_req) begin
                            if (ld_val > 4'd9) begin
                                r_ack <= 1'b1;
                                r_err <= 1'b1;
                            end else begin
                                r_state <= LOAD;
                                r_pl_n  <= 1'b0;
                                r_p     <= ld_val;
                                r_tmr   <= W_LAST;
                            end
                        end else if (up_req && dn_req) begin
                            r_ack <= 1'b1;
                        end else if (up_req) begin
                            r_state <= UP_LO;
                            r_cpu   <= 1'b0;
                            r_tmr   <= W_LAST;
                        end else if (dn_req) begin
                            r_state <= DN_LO;
                            r_cpd   <= 1'b0;
                            r_tmr   <= W_LAST;
                        end
                    end
                end
                CLR, LOAD, UP_LO, DN_LO: begin
                    if (r_tmr == 4'd0) begin
                        r_state <= REC;
                        r_tmr   <= W_LAST;
                        r_ack   <= (W_LAST == 4'd0);
                        r_mr    <= 1'b0;
                        r_pl_n  <= 1'b1;
                        r_cpu   <= 1'b1;
                        r_cpd   <= 1'b1;
                        // Shadow count follows the counter on the releasing edge.
                        if (r_state == CLR) begin
                            r_cnt <= 4'd0;
                        end else if (r_state == LOAD) begin
                            r_cnt <= r_p;
                        end else if (r_state == UP_LO) begin
                            r_cnt <= (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;
                        end else begin
                            r_cnt <= (r_cnt == 4'd0) ? 4'd9 : r_cnt - 4'd1;
                        end
                    end else begin
                        r_tmr <= r_tmr - 4'd1;
                    end
                end
                REC: begin
                    if (r_tmr == 4'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_tmr <= r_tmr - 4'd1;
                        r_ack <= (r_tmr == 4'd1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = (r_state != IDLE);
    assign CPu   = r_cpu;
    assign CPd   = r_cpd;
    assign PL_n  = r_pl_n;
    assign MR    = r_mr;
    assign P3    = r_p[3];
    assign P2    = r_p[2];
    assign P1    = r_p[1];
    assign P0    = r_p[0];
    assign cnt   = r_cnt;
    assign tc_up = (r_cnt == 4'd9);
    assign tc_dn = (r_cnt == 4'd0);

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// Directed bench for decade_counter_ctrl: PULSE_W=1 instance driven from a vector table,
// plus a PULSE_W=3 instance for pulse stretching and mid-operation reset.
module tb_decade_counter_ctrl;

    localparam logic [3:0] M_CLR = 4'b1000;
    localparam logic [3:0] M_LD  = 4'b0100;
    localparam logic [3:0] M_UP  = 4'b0010;
    localparam logic [3:0] M_DN  = 4'b0001;

    logic       CP = 1'b0;
    logic       rst_n, up_req, dn_req, ld_req, clr_req;
    logic [3:0] ld_val;
    logic       ack, err, busy, CPu, CPd, PL_n, MR, P3, P2, P1, P0, tc_up, tc_dn;
    logic [3:0] cnt;

    logic       rst3_n, up3;
    logic       ack3, err3, busy3, CPu3, CPd3, PL_n3, MR3, P3_3, P2_3, P1_3, P0_3, tcu3, tcd3;
    logic [3:0] cnt3;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CP = ~CP;

    decade_counter_ctrl #(.PULSE_W(1)) dut (
        .CP(CP), .MR_n(rst_n), .up_req(up_req), .dn_req(dn_req), .ld_req(ld_req),
        .ld_val(ld_val), .clr_req(clr_req), .ack(ack), .err(err), .busy(busy),
        .CPu(CPu), .CPd(CPd), .PL_n(PL_n), .MR(MR), .P3(P3), .P2(P2), .P1(P1), .P0(P0),
        .cnt(cnt), .tc_up(tc_up), .tc_dn(tc_dn)
    );

    decade_counter_ctrl #(.PULSE_W(3)) dut3 (
        .CP(CP), .MR_n(rst3_n), .up_req(up3), .dn_req(1'b0), .ld_req(1'b0),
        .ld_val(4'd0), .clr_req(1'b0), .ack(ack3), .err(err3), .busy(busy3),
        .CPu(CPu3), .CPd(CPd3), .PL_n(PL_n3), .MR(MR3), .P3(P3_3), .P2(P2_3), .P1(P1_3),
        .P0(P0_3), .cnt(cnt3), .tc_up(tcu3), .tc_dn(tcd3)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] val;
        int         ack_cyc;
        int         n_cpu;
        int         n_cpd;
        int         n_pl;
        int         n_mr;
        int         n_busy;
        logic       err;
        logic [3:0] cnt;
        logic       tc_up;
        logic       tc_dn;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raise the masked requests, watch every cycle until ack (bounded), drop requests on ack.
    task automatic run_op(input logic [3:0] req, input logic [3:0] val, input logic keep_ld,
                          output int ack_cyc, output int n_cpu, output int n_cpd,
                          output int n_pl, output int n_mr, output int n_busy,
                          output logic err_seen, output logic excl_bad);
        ack_cyc = 0; n_cpu = 0; n_cpd = 0; n_pl = 0; n_mr = 0; n_busy = 0;
        err_seen = 1'b0; excl_bad = 1'b0;
        @(negedge CP);
        clr_req = req[3]; ld_req = req[2]; up_req = req[1]; dn_req = req[0];
        if (req[2]) ld_val = val;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CP);
            n_cpu  += int'(!CPu);
            n_cpd  += int'(!CPd);
            n_pl   += int'(!PL_n);
            n_mr   += int'(MR);
            n_busy += int'(busy);
            if ((int'(!CPu) + int'(!CPd) + int'(!PL_n) + int'(MR)) > 1) excl_bad = 1'b1;
            if (err && !ack) err_seen = 1'b1;
            if (ack) begin
                ack_cyc  = cyc;
                err_seen = err_seen | err;
                break;
            end
        end
        clr_req = 1'b0; up_req = 1'b0; dn_req = 1'b0;
        if (!keep_ld) ld_req = 1'b0;
    endtask

    vec_t vecs[13];

    initial begin
        logic [3:0] exp_p;
        int         a, ncu, ncd, npl, nmr, nb;
        logic       e, x;

        vecs[0]  = '{M_LD, 4'd5,  2, 0, 0, 1, 0, 2, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[1]  = '{M_UP, 4'd0,  2, 1, 0, 0, 0, 2, 1'b0, 4'd6, 1'b0, 1'b0};
        vecs[2]  = '{M_UP, 4'd0,  2, 1, 0, 0, 0, 2, 1'b0, 4'd7, 1'b0, 1'b0};
        vecs[3]  = '{M_DN, 4'd0,  2, 0, 1, 0, 0, 2, 1'b0, 4'd6, 1'b0, 1'b0};
        vecs[4]  = '{M_DN, 4'd0,  2, 0, 1, 0, 0, 2, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[5]  = '{M_LD, 4'd9,  2, 0, 0, 1, 0, 2, 1'b0, 4'd9, 1'b1, 1'b0};
        vecs[6]  = '{M_UP, 4'd0,  2, 1, 0, 0, 0, 2, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[7]  = '{M_DN, 4'd0,  2, 0, 1, 0, 0, 2, 1'b0, 4'd9, 1'b1, 1'b0};
        vecs[8]  = '{M_UP | M_DN, 4'd0, 1, 0, 0, 0, 0, 0, 1'b0, 4'd9, 1'b1, 1'b0};
        vecs[9]  = '{M_LD, 4'd12, 1, 0, 0, 0, 0, 0, 1'b1, 4'd9, 1'b1, 1'b0};
        vecs[10] = '{M_CLR, 4'd0, 2, 0, 0, 0, 1, 2, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[11] = '{M_DN, 4'd0,  2, 0, 1, 0, 0, 2, 1'b0, 4'd9, 1'b1, 1'b0};
        vecs[12] = '{M_UP, 4'd0,  2, 1, 0, 0, 0, 2, 1'b0, 4'd0, 1'b0, 1'b1};

        rst_n = 1'b0; rst3_n = 1'b0; up3 = 1'b0;
        up_req = 1'b0; dn_req = 1'b0; ld_req = 1'b0; clr_req = 1'b0; ld_val = 4'd0;
        exp_p = 4'd0;

        repeat (2) @(negedge CP);
        chk("rst CPu", int'(CPu), 1);
        chk("rst CPd", int'(CPd), 1);
        chk("rst PL_n", int'(PL_n), 1);
        chk("rst MR", int'(MR), 1);
        chk("rst P", int'({P3, P2, P1, P0}), 0);
        chk("rst cnt", int'(cnt), 0);
        chk("rst ack/err/busy", int'({ack, err, busy}), 0);
        rst_n = 1'b1; rst3_n = 1'b1;
        @(negedge CP);
        chk("MR after release", int'(MR), 0);
        chk("MR3 after release", int'(MR3), 0);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].req, vecs[i].val, 1'b0, a, ncu, ncd, npl, nmr, nb, e, x);
            if (vecs[i].req == M_LD && vecs[i].val <= 4'd9) exp_p = vecs[i].val;
            chk($sformatf("v%0d ack_cyc", i), a, vecs[i].ack_cyc);
            chk($sformatf("v%0d CPu lows", i), ncu, vecs[i].n_cpu);
            chk($sformatf("v%0d CPd lows", i), ncd, vecs[i].n_cpd);
            chk($sformatf("v%0d PL_n lows", i), npl, vecs[i].n_pl);
            chk($sformatf("v%0d MR highs", i), nmr, vecs[i].n_mr);
            chk($sformatf("v%0d busy cycles", i), nb, vecs[i].n_busy);
            chk($sformatf("v%0d err", i), int'(e), int'(vecs[i].err));
            chk($sformatf("v%0d cnt", i), int'(cnt), int'(vecs[i].cnt));
            chk($sformatf("v%0d tc_up", i), int'(tc_up), int'(vecs[i].tc_up));
            chk($sformatf("v%0d tc_dn", i), int'(tc_dn), int'(vecs[i].tc_dn));
            chk($sformatf("v%0d P3..P0", i), int'({P3, P2, P1, P0}), int'(exp_p));
            chk($sformatf("v%0d exclusive", i), int'(x), 0);
        end

        // Clear and load together: clear first, held load served afterwards.
        run_op(M_CLR | M_LD, 4'd3, 1'b1, a, ncu, ncd, npl, nmr, nb, e, x);
        chk("clr+ld first ack", a, 2);
        chk("clr+ld MR highs", nmr, 1);
        chk("clr+ld no PL_n", npl, 0);
        chk("clr+ld cnt", int'(cnt), 0);
        run_op(M_LD, 4'd3, 1'b0, a, ncu, ncd, npl, nmr, nb, e, x);
        chk("held ld ack", a, 2);
        chk("held ld PL_n lows", npl, 1);
        chk("held ld cnt", int'(cnt), 3);
        chk("held ld P3..P0", int'({P3, P2, P1, P0}), 3);

        // PULSE_W=3: full up operation stretches low and recovery phases.
        @(negedge CP);
        up3 = 1'b1;
        a = 0; ncu = 0; nb = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CP);
            ncu += int'(!CPu3);
            nb  += int'(busy3);
            if (ack3) begin
                a = cyc;
                break;
            end
        end
        up3 = 1'b0;
        chk("w3 ack_cyc", a, 6);
        chk("w3 CPu lows", ncu, 3);
        chk("w3 busy cycles", nb, 6);
        chk("w3 cnt", int'(cnt3), 1);

        // PULSE_W=3: reset in the middle of UP_LO aborts at once.
        @(negedge CP);
        up3 = 1'b1;
        a = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CP);
            if (!CPu3) begin
                a = cyc;
                break;
            end
        end
        chk("w3 CPu low seen", a, 1);
        @(negedge CP);
        #2 rst3_n = 1'b0;
        #1;
        chk("abort CPu", int'(CPu3), 1);
        chk("abort MR", int'(MR3), 1);
        chk("abort cnt", int'(cnt3), 0);
        chk("abort ack/busy", int'({ack3, busy3}), 0);
        up3 = 1'b0;
        @(negedge CP);
        rst3_n = 1'b1;
        a = 0;
        repeat (8) begin
            @(negedge CP);
            a += int'(ack3);
        end
        chk("abort no ack", a, 0);
        chk("abort MR released", int'(MR3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
